// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART byte sender between NUM_REQ requesters
//   sys_clk   in  : system clock, rising edge
//   reset     in  : asynchronous active-low reset
//   req       in  : per-requester level request, held until ack
//   req_data  in  : byte of requester i at [8*i+7:8*i]
//   ack       out : one-cycle pulse, byte of requester i accepted
//   tx_data   out : byte to sender, held from launch until back in IDLE
//   tx_en     out : one-cycle launch strobe to sender
//   tx_status in  : sender status, 1 = idle/ready, 0 = transmitting
//   busy      out : 1 whenever the scheduler is not IDLE
//   grant_id  out : index of last granted requester
//   tx_err    out : one-cycle pulse, sender never went busy after launch
module uart_tx_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 16
) (
   input  logic                 sys_clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   ack,
   output logic [7:0]           tx_data,
   output logic                 tx_en,
   input  logic                 tx_status,
   output logic                 busy,
   output logic [2:0]           grant_id,
   output logic                 tx_err
);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
   state_t state_q, state_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d, rot;
   logic [2*NUM_REQ-1:0] dbl;
   logic [7:0]           tx_data_q, tx_data_d, cnt_q, cnt_d;
   logic [2:0]           grant_id_q, grant_id_d, ptr_q, ptr_d, off, win;
   logic [3:0]           sum;
   logic                 tx_en_q, tx_en_d, busy_q, busy_d, tx_err_q, tx_err_d;
   logic                 grant, timeout;
   // ptr_q holds where the next search starts, so requester 0 leads after reset
   always_comb begin
      dbl = {req, req} >> ptr_q;
      rot = dbl[NUM_REQ-1:0];
      off = '0;
      for (int i = NUM_REQ-1; i >= 0; i--)
         if (rot[i]) off = 3'(i);
      sum = {1'b0, ptr_q} + {1'b0, off};
      win = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
   end
   assign grant   = (state_q == IDLE) && (|req) && tx_status;
   assign timeout = tx_status && (cnt_q >= 8'(START_TIMEOUT-1));
   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ack_q      <= '0;
         tx_data_q  <= '0;
         tx_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         grant_id_q <= '0;
         tx_err_q   <= 1'b0;
         cnt_q      <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         tx_data_q  <= tx_data_d;
         tx_en_q    <= tx_en_d;
         busy_q     <= busy_d;
         grant_id_q <= grant_id_d;
         tx_err_q   <= tx_err_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
      end
   end
   // tx_status is deliberately not examined in LAUNCH: the sender reacts one cycle late
   always_comb begin
      state_d = (state_q == IDLE)      ? (grant ? LAUNCH : IDLE) :
                (state_q == LAUNCH)    ? WAIT_BUSY :
                (state_q == WAIT_BUSY) ? (!tx_status ? WAIT_DONE : (timeout ? IDLE : WAIT_BUSY)) :
                                         (tx_status ? IDLE : WAIT_DONE);
   end
   // the timeout counter clears while launching and saturates instead of wrapping
   always_comb begin
      ack_d      = grant ? NUM_REQ'(1) << win : '0;
      tx_en_d    = grant;
      tx_data_d  = grant ? req_data[8*win +: 8] : tx_data_q;
      grant_id_d = grant ? win : grant_id_q;
      ptr_d      = grant ? ((win == 3'(NUM_REQ-1)) ? 3'd0 : win + 3'd1) : ptr_q;
      cnt_d      = (state_q == LAUNCH) ? 8'd0 :
                   ((state_q == WAIT_BUSY) && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
      tx_err_d   = (state_q == WAIT_BUSY) && timeout;
      busy_d     = (state_d != IDLE);
   end
   assign ack      = ack_q;
   assign tx_data  = tx_data_q;
   assign tx_en    = tx_en_q;
   assign busy     = busy_q;
   assign grant_id = grant_id_q;
   assign tx_err   = tx_err_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed self-checking bench for uart_tx_scheduler with a simple sender model
module tb_uart_tx_scheduler;
   localparam int N     = 4;
   localparam int TOUT  = 16;
   localparam int FRAME = 5;
   logic           sys_clk, reset, tx_status, tx_en, busy, tx_err, sender_dead;
   logic [N-1:0]   req, ack;
   logic [8*N-1:0] req_data;
   logic [7:0]     tx_data;
   logic [2:0]     grant_id;
   int             busy_cnt, errors, checks;
   uart_tx_scheduler #(.NUM_REQ(N), .START_TIMEOUT(TOUT)) dut (
      .sys_clk(sys_clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
      .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status), .busy(busy),
      .grant_id(grant_id), .tx_err(tx_err)
   );
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;
   // sender: goes busy the cycle after tx_en and stays busy for FRAME cycles
   always @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         tx_status <= 1'b1;
         busy_cnt  <= 0;
      end else if (tx_en && !sender_dead) begin
         tx_status <= 1'b0;
         busy_cnt  <= FRAME;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else if (busy_cnt == 1) begin
         busy_cnt  <= 0;
         tx_status <= 1'b1;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic expect_launch(input string tag, input logic [N-1:0] a, input logic [7:0] d, input logic [2:0] id);
      @(negedge sys_clk);
      chk({tag, " tx_en"}, tx_en, 1);
      chk({tag, " ack"}, ack, a);
      chk({tag, " tx_data"}, tx_data, d);
      chk({tag, " grant_id"}, grant_id, id);
      chk({tag, " busy"}, busy, 1);
      req = req & ~a;
      @(negedge sys_clk);
      chk({tag, " tx_en pulse"}, tx_en, 0);
      chk({tag, " ack pulse"}, ack, 0);
   endtask
   task automatic wait_idle(input string tag, input logic [7:0] d);
      int n = 0;
      while (busy === 1'b1 && n < 40) begin
         chk({tag, " hold"}, tx_data, d);
         @(negedge sys_clk);
         n++;
      end
      chk({tag, " idle"}, busy, 0);
      chk({tag, " kept"}, tx_data, d);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      errors = 0; checks = 0;
      reset = 1'b0; req = '0; req_data = '0; sender_dead = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("rst busy", busy, 0);
      chk("rst tx_en", tx_en, 0);
      chk("rst ack", ack, 0);
      chk("rst tx_data", tx_data, 0);
      chk("rst grant_id", grant_id, 0);
      chk("rst tx_err", tx_err, 0);
      reset = 1'b1;
      @(negedge sys_clk);
      // all four request at once: served 0,1,2,3, one per frame
      req_data = 32'h13121110; req = 4'b1111;
      expect_launch("rr0", 4'b0001, 8'h10, 3'd0); wait_idle("rr0", 8'h10);
      expect_launch("rr1", 4'b0010, 8'h11, 3'd1); wait_idle("rr1", 8'h11);
      expect_launch("rr2", 4'b0100, 8'h12, 3'd2); wait_idle("rr2", 8'h12);
      expect_launch("rr3", 4'b1000, 8'h13, 3'd3); wait_idle("rr3", 8'h13);
      // single requester 2
      req_data = 32'h00550000; req = 4'b0100;
      expect_launch("one", 4'b0100, 8'h55, 3'd2); wait_idle("one", 8'h55);
      // grant 1, then 0 and 3 together: 3 first
      req_data = 32'h00002100; req = 4'b0010;
      expect_launch("g1", 4'b0010, 8'h21, 3'd1); wait_idle("g1", 8'h21);
      req_data = 32'h33000030; req = 4'b1001;
      expect_launch("wrap3", 4'b1000, 8'h33, 3'd3); wait_idle("wrap3", 8'h33);
      expect_launch("wrap0", 4'b0001, 8'h30, 3'd0); wait_idle("wrap0", 8'h30);
      // sender never goes busy: timeout
      sender_dead = 1'b1;
      req_data = 32'h0000A500; req = 4'b0010;
      expect_launch("tout", 4'b0010, 8'hA5, 3'd1);
      for (int k = 1; k <= TOUT; k++) begin
         @(negedge sys_clk);
         chk("tout tx_err", tx_err, (k == TOUT) ? 1 : 0);
      end
      chk("tout busy", busy, 0);
      @(negedge sys_clk);
      chk("tout err pulse", tx_err, 0);
      chk("tout data", tx_data, 8'hA5);
      sender_dead = 1'b0;
      // reset in WAIT_DONE, then restart from requester 0
      req_data = 32'h005C0000; req = 4'b0100;
      expect_launch("mid", 4'b0100, 8'h5C, 3'd2);
      @(negedge sys_clk);
      chk("mid busy before", busy, 1);
      reset = 1'b0;
      #1;
      chk("mid rst busy", busy, 0);
      chk("mid rst tx_en", tx_en, 0);
      chk("mid rst ack", ack, 0);
      chk("mid rst tx_data", tx_data, 0);
      @(negedge sys_clk);
      reset = 1'b1;
      req_data = 32'h43000040; req = 4'b1001;
      expect_launch("post", 4'b0001, 8'h40, 3'd0); wait_idle("post", 8'h40);
      // requester 1 withdraws one cycle before the sender is idle again
      expect_launch("drop", 4'b1000, 8'h43, 3'd3);
      req_data[15:8] = 8'h66; req[1] = 1'b1;
      for (int n = 0; n < 20 && busy_cnt != 1; n++) @(negedge sys_clk);
      chk("drop sync", busy_cnt, 1);
      req[1] = 1'b0;
      wait_idle("drop", 8'h43);
      for (int k = 0; k < 3; k++) begin
         @(negedge sys_clk);
         chk("drop tx_en", tx_en, 0);
         chk("drop ack", ack, 0);
         chk("drop busy", busy, 0);
         chk("drop tx_data", tx_data, 8'h43);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
